// File: rtl/rx_resp_collector.sv
// Response collector: per-instance op_id FIFOs paired with acked read data, round-robin output.
// Optional sticky error flags (err_*, err_clr) exist only when RX_RESP_COLLECT_ERR_EN is defined.
module rx_resp_collector #(
  parameter int NUM_SW_INST = 5,
  parameter int W_WIDTH     = 8,
  parameter int OP_ID_WIDTH = 8,
  parameter int DEPTH       = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_SW_INST-1:0]           sel_en,
  input  logic [OP_ID_WIDTH-1:0]           op_id,
  input  logic [NUM_SW_INST-1:0]           ack,
  input  logic [NUM_SW_INST*W_WIDTH-1:0]   rd_data,
  output logic [NUM_SW_INST-1:0]           sw_busy,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [W_WIDTH-1:0]               resp_data,
  output logic [OP_ID_WIDTH-1:0]           resp_op_id,
  output logic [$clog2(NUM_SW_INST)-1:0]   resp_sw_idx
`ifdef RX_RESP_COLLECT_ERR_EN
  ,
  input  logic                             err_clr,
  output logic                             err_unexp_ack,
  output logic                             err_issue_ovf,
  output logic                             err_slot_ovf
`endif
);

  localparam int IDX_W = $clog2(NUM_SW_INST);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [OP_ID_WIDTH-1:0] mem_q [NUM_SW_INST][DEPTH];
  logic [OP_ID_WIDTH-1:0] mem_d [NUM_SW_INST][DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q [NUM_SW_INST];
  logic [PTR_W-1:0]       wr_ptr_d [NUM_SW_INST];
  logic [PTR_W-1:0]       rd_ptr_q [NUM_SW_INST];
  logic [PTR_W-1:0]       rd_ptr_d [NUM_SW_INST];
  logic [CNT_W-1:0]       cnt_q    [NUM_SW_INST];
  logic [CNT_W-1:0]       cnt_d    [NUM_SW_INST];

  logic [NUM_SW_INST-1:0] slot_vld_q, slot_vld_d;
  logic [OP_ID_WIDTH-1:0] slot_op_q   [NUM_SW_INST];
  logic [OP_ID_WIDTH-1:0] slot_op_d   [NUM_SW_INST];
  logic [W_WIDTH-1:0]     slot_data_q [NUM_SW_INST];
  logic [W_WIDTH-1:0]     slot_data_d [NUM_SW_INST];

  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [W_WIDTH-1:0]     resp_data_q, resp_data_d;
  logic [OP_ID_WIDTH-1:0] resp_op_id_q, resp_op_id_d;
  logic [IDX_W-1:0]       resp_sw_idx_q, resp_sw_idx_d;

  logic                   issue_any;
  logic [IDX_W-1:0]       issue_idx;
  logic                   out_free;
  logic                   grant_vld;
  logic [IDX_W-1:0]       grant_idx;
  logic [NUM_SW_INST-1:0] push, pop, slot_free;

  // Descending scan so the lowest-index strobe is the one that sticks.
  always_comb begin
    issue_any = 1'b0;
    issue_idx = '0;
    for (int i = NUM_SW_INST - 1; i >= 0; i--) begin
      if (sel_en[i]) begin
        issue_any = 1'b1;
        issue_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    logic [IDX_W-1:0] cand;
    out_free  = !resp_valid_q || resp_ready;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_SW_INST; k++) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_SW_INST);
      if (out_free && !grant_vld && slot_vld_q[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // A slot granted this cycle can be refilled by a same-cycle ack.
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    slot_vld_d  = slot_vld_q;
    slot_op_d   = slot_op_q;
    slot_data_d = slot_data_q;
    push        = '0;
    pop         = '0;
    slot_free   = '0;
    for (int i = 0; i < NUM_SW_INST; i++) begin
      slot_free[i] = !slot_vld_q[i] || (grant_vld && grant_idx == IDX_W'(i));
      push[i]      = issue_any && issue_idx == IDX_W'(i) && cnt_q[i] != FULL_CNT;
      pop[i]       = ack[i] && cnt_q[i] != '0 && slot_free[i];
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = op_id;
        wr_ptr_d[i]           = wr_ptr_q[i] + PTR_W'(1);
      end
      if (grant_vld && grant_idx == IDX_W'(i)) begin
        slot_vld_d[i] = 1'b0;
      end
      if (pop[i]) begin
        slot_vld_d[i]  = 1'b1;
        slot_op_d[i]   = mem_q[i][rd_ptr_q[i]];
        slot_data_d[i] = rd_data[i*W_WIDTH +: W_WIDTH];
        rd_ptr_d[i]    = rd_ptr_q[i] + PTR_W'(1);
      end
      cnt_d[i] = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
    end
  end

  always_comb begin
    resp_valid_d  = resp_valid_q;
    resp_data_d   = resp_data_q;
    resp_op_id_d  = resp_op_id_q;
    resp_sw_idx_d = resp_sw_idx_q;
    rr_ptr_d      = rr_ptr_q;
    if (grant_vld) begin
      resp_valid_d  = 1'b1;
      resp_data_d   = slot_data_q[grant_idx];
      resp_op_id_d  = slot_op_q[grant_idx];
      resp_sw_idx_d = grant_idx;
      rr_ptr_d      = grant_idx;
    end else if (resp_ready) begin
      resp_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SW_INST; i++) begin
        wr_ptr_q[i]    <= '0;
        rd_ptr_q[i]    <= '0;
        cnt_q[i]       <= '0;
        slot_op_q[i]   <= '0;
        slot_data_q[i] <= '0;
      end
      slot_vld_q    <= '0;
      rr_ptr_q      <= IDX_W'(NUM_SW_INST - 1);
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      resp_op_id_q  <= '0;
      resp_sw_idx_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      slot_op_q     <= slot_op_d;
      slot_data_q   <= slot_data_d;
      slot_vld_q    <= slot_vld_d;
      rr_ptr_q      <= rr_ptr_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      resp_op_id_q  <= resp_op_id_d;
      resp_sw_idx_q <= resp_sw_idx_d;
    end
  end

  // FIFO storage needs no reset; the pointers and counts define what is live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    for (int i = 0; i < NUM_SW_INST; i++) begin
      sw_busy[i] = (cnt_q[i] == FULL_CNT);
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign resp_op_id  = resp_op_id_q;
  assign resp_sw_idx = resp_sw_idx_q;

`ifdef RX_RESP_COLLECT_ERR_EN
  logic unexp_evt, issue_evt, slot_evt;
  logic err_unexp_ack_q, err_unexp_ack_d;
  logic err_issue_ovf_q, err_issue_ovf_d;
  logic err_slot_ovf_q, err_slot_ovf_d;

  // A new event wins over err_clr in the same cycle.
  always_comb begin
    unexp_evt = 1'b0;
    slot_evt  = 1'b0;
    for (int i = 0; i < NUM_SW_INST; i++) begin
      if (ack[i] && cnt_q[i] == '0) unexp_evt = 1'b1;
      if (ack[i] && cnt_q[i] != '0 && !slot_free[i]) slot_evt = 1'b1;
    end
    issue_evt       = issue_any && (push == '0);
    err_unexp_ack_d = unexp_evt || (err_unexp_ack_q && !err_clr);
    err_issue_ovf_d = issue_evt || (err_issue_ovf_q && !err_clr);
    err_slot_ovf_d  = slot_evt  || (err_slot_ovf_q  && !err_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_unexp_ack_q <= 1'b0;
      err_issue_ovf_q <= 1'b0;
      err_slot_ovf_q  <= 1'b0;
    end else begin
      err_unexp_ack_q <= err_unexp_ack_d;
      err_issue_ovf_q <= err_issue_ovf_d;
      err_slot_ovf_q  <= err_slot_ovf_d;
    end
  end

  assign err_unexp_ack = err_unexp_ack_q;
  assign err_issue_ovf = err_issue_ovf_q;
  assign err_slot_ovf  = err_slot_ovf_q;
`endif

endmodule

// File: tb/tb_rx_resp_collector.sv
// Directed bench for rx_resp_collector: expected responses are queued when acks are driven
// and compared when the DUT hands them off; error flags are checked when RX_RESP_COLLECT_ERR_EN is set.
module tb_rx_resp_collector;

  localparam int N  = 5;
  localparam int W  = 8;
  localparam int OW = 8;
  localparam int IW = $clog2(N);

  typedef struct packed {
    logic [W-1:0]  data;
    logic [OW-1:0] op;
    logic [IW-1:0] idx;
  } resp_t;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    sel_en;
  logic [OW-1:0]   op_id;
  logic [N-1:0]    ack;
  logic [N*W-1:0]  rd_data;
  logic [N-1:0]    sw_busy;
  logic            resp_valid;
  logic            resp_ready;
  logic [W-1:0]    resp_data;
  logic [OW-1:0]   resp_op_id;
  logic [IW-1:0]   resp_sw_idx;
`ifdef RX_RESP_COLLECT_ERR_EN
  logic            err_clr;
  logic            err_unexp_ack;
  logic            err_issue_ovf;
  logic            err_slot_ovf;
`endif

  int    checks = 0;
  int    errors = 0;
  resp_t sb[$];

  rx_resp_collector #(.NUM_SW_INST(N), .W_WIDTH(W), .OP_ID_WIDTH(OW), .DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sel_en      (sel_en),
    .op_id       (op_id),
    .ack         (ack),
    .rd_data     (rd_data),
    .sw_busy     (sw_busy),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_op_id  (resp_op_id),
    .resp_sw_idx (resp_sw_idx)
`ifdef RX_RESP_COLLECT_ERR_EN
    ,
    .err_clr       (err_clr),
    .err_unexp_ack (err_unexp_ack),
    .err_issue_ovf (err_issue_ovf),
    .err_slot_ovf  (err_slot_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] sel, input logic [OW-1:0] id,
                               input logic [N-1:0] ak, input logic [N*W-1:0] rd);
    sel_en  = sel;
    op_id   = id;
    ack     = ak;
    rd_data = rd;
    tick();
    sel_en  = '0;
    ack     = '0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pushExp(input logic [W-1:0] d, input logic [OW-1:0] o, input logic [IW-1:0] x);
    resp_t r;
    r.data = d;
    r.op   = o;
    r.idx  = x;
    sb.push_back(r);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [N*W-1:0] slice(input int idx, input logic [W-1:0] val);
    logic [N*W-1:0] r;
    r = '0;
    r[idx*W +: W] = val;
    return r;
  endfunction

  // Scoreboard side: every handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      resp_t e;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("[TB] FAIL unexpected_resp: observed idx %0d op 0x%0h data 0x%0h, expected no response",
               resp_sw_idx, resp_op_id, resp_data);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("sb_data",  64'(resp_data),   64'(e.data));
        checkOutput("sb_op_id", 64'(resp_op_id),  64'(e.op));
        checkOutput("sb_idx",   64'(resp_sw_idx), 64'(e.idx));
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    sel_en     = '0;
    op_id      = '0;
    ack        = '0;
    rd_data    = '0;
    resp_ready = 1'b1;
`ifdef RX_RESP_COLLECT_ERR_EN
    err_clr    = 1'b0;
`endif
    drain(2);
    rst_n = 1'b1;
    checkOutput("rst_valid",   64'(resp_valid),  64'd0);
    checkOutput("rst_data",    64'(resp_data),   64'd0);
    checkOutput("rst_op_id",   64'(resp_op_id),  64'd0);
    checkOutput("rst_idx",     64'(resp_sw_idx), 64'd0);
    checkOutput("rst_sw_busy", 64'(sw_busy),     64'd0);
`ifdef RX_RESP_COLLECT_ERR_EN
    checkOutput("rst_err", 64'({err_unexp_ack, err_issue_ovf, err_slot_ovf}), 64'd0);
`endif

    // Two ops in order on instance 2.
    applyStimulus(5'b00100, 8'h11, '0, '0);
    applyStimulus(5'b00100, 8'h22, '0, '0);
    applyStimulus('0, '0, 5'b00100, slice(2, 8'hA0));
    pushExp(8'hA0, 8'h11, 3'd2);
    applyStimulus('0, '0, 5'b00100, slice(2, 8'hB0));
    pushExp(8'hB0, 8'h22, 3'd2);
    drain(4);
    checkOutput("t1_drained", 64'(sb.size()), 64'd0);
    checkOutput("t1_idle", 64'(resp_valid), 64'd0);

    // Fill instance 0, overflow it, then drain it.
    applyStimulus(5'b00001, 8'h30, '0, '0);
    applyStimulus(5'b00001, 8'h31, '0, '0);
    applyStimulus(5'b00001, 8'h32, '0, '0);
    checkOutput("t2_busy_3", 64'(sw_busy), 64'd0);
    applyStimulus(5'b00001, 8'h33, '0, '0);
    checkOutput("t2_busy_4", 64'(sw_busy), 64'h01);
    applyStimulus(5'b00001, 8'h34, '0, '0);
    checkOutput("t2_busy_ovf", 64'(sw_busy), 64'h01);
`ifdef RX_RESP_COLLECT_ERR_EN
    checkOutput("t2_err_issue", 64'(err_issue_ovf), 64'd1);
`endif
    applyStimulus('0, '0, 5'b00001, slice(0, 8'hC0));
    pushExp(8'hC0, 8'h30, 3'd0);
    checkOutput("t2_busy_pop", 64'(sw_busy), 64'd0);
    applyStimulus('0, '0, 5'b00001, slice(0, 8'hC1));
    pushExp(8'hC1, 8'h31, 3'd0);
    applyStimulus('0, '0, 5'b00001, slice(0, 8'hC2));
    pushExp(8'hC2, 8'h32, 3'd0);
    applyStimulus('0, '0, 5'b00001, slice(0, 8'hC3));
    pushExp(8'hC3, 8'h33, 3'd0);
    applyStimulus('0, '0, 5'b00001, slice(0, 8'hC4));
    drain(5);
    checkOutput("t2_drained", 64'(sb.size()), 64'd0);
    checkOutput("t2_idle", 64'(resp_valid), 64'd0);

    // Simultaneous acks on 0, 1, 3 from a fresh round-robin pointer.
    doReset();
    applyStimulus(5'b00001, 8'h40, '0, '0);
    applyStimulus(5'b00010, 8'h41, '0, '0);
    applyStimulus(5'b01000, 8'h43, '0, '0);
    applyStimulus('0, '0, 5'b01011, slice(0, 8'hD0) | slice(1, 8'hD1) | slice(3, 8'hD3));
    pushExp(8'hD0, 8'h40, 3'd0);
    pushExp(8'hD1, 8'h41, 3'd1);
    pushExp(8'hD3, 8'h43, 3'd3);
    checkOutput("t3_latency", 64'(resp_valid), 64'd0);
    tick();
    checkOutput("t3_idx0", 64'({resp_valid, resp_sw_idx}), 64'({1'b1, 3'd0}));
    tick();
    checkOutput("t3_idx1", 64'({resp_valid, resp_sw_idx}), 64'({1'b1, 3'd1}));
    tick();
    checkOutput("t3_idx3", 64'({resp_valid, resp_sw_idx}), 64'({1'b1, 3'd3}));
    tick();
    checkOutput("t3_idle", 64'(resp_valid), 64'd0);
    checkOutput("t3_drained", 64'(sb.size()), 64'd0);

    // Unexpected ack on 4 with a same-cycle issue that must still be recorded.
    applyStimulus(5'b10000, 8'h44, 5'b10000, slice(4, 8'hEE));
`ifdef RX_RESP_COLLECT_ERR_EN
    checkOutput("t4_err_unexp", 64'(err_unexp_ack), 64'd1);
`endif
    tick();
    checkOutput("t4_no_resp", 64'(resp_valid), 64'd0);
    applyStimulus('0, '0, 5'b10000, slice(4, 8'hE4));
    pushExp(8'hE4, 8'h44, 3'd4);
    drain(3);
    checkOutput("t4_drained", 64'(sb.size()), 64'd0);
`ifdef RX_RESP_COLLECT_ERR_EN
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("t4_err_clr", 64'(err_unexp_ack), 64'd0);
    err_clr = 1'b1;
    applyStimulus('0, '0, 5'b10000, '0);
    err_clr = 1'b0;
    checkOutput("t4_clr_vs_set", 64'(err_unexp_ack), 64'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("t4_err_clr2", 64'(err_unexp_ack), 64'd0);
`endif

    // Back-pressure: second ack on instance 1 overflows its slot.
    applyStimulus(5'b00100, 8'h50, '0, '0);
    applyStimulus(5'b00010, 8'h51, '0, '0);
    applyStimulus(5'b00010, 8'h52, '0, '0);
    resp_ready = 1'b0;
    applyStimulus('0, '0, 5'b00100, slice(2, 8'hF2));
    pushExp(8'hF2, 8'h50, 3'd2);
    tick();
    checkOutput("t5_presented", 64'({resp_valid, resp_data, resp_op_id, resp_sw_idx}),
                64'({1'b1, 8'hF2, 8'h50, 3'd2}));
    applyStimulus('0, '0, 5'b00010, slice(1, 8'hF1));
    pushExp(8'hF1, 8'h51, 3'd1);
    applyStimulus('0, '0, 5'b00010, slice(1, 8'hFF));
    checkOutput("t5_stable", 64'({resp_valid, resp_data, resp_op_id, resp_sw_idx}),
                64'({1'b1, 8'hF2, 8'h50, 3'd2}));
`ifdef RX_RESP_COLLECT_ERR_EN
    checkOutput("t5_err_slot", 64'(err_slot_ovf), 64'd1);
`endif
    resp_ready = 1'b1;
    applyStimulus('0, '0, 5'b00010, slice(1, 8'hF3));
    pushExp(8'hF3, 8'h52, 3'd1);
    drain(4);
    checkOutput("t5_drained", 64'(sb.size()), 64'd0);

    // Multi-bit sel_en: only instance 1 records the op.
    applyStimulus(5'b10110, 8'h07, '0, '0);
    applyStimulus('0, '0, 5'b10110, slice(1, 8'hA7) | slice(2, 8'hA2) | slice(4, 8'hA4));
    pushExp(8'hA7, 8'h07, 3'd1);
    drain(3);
    checkOutput("t6_drained", 64'(sb.size()), 64'd0);

    // Mid-stream reset discards outstanding ops, slots and the presented response.
    applyStimulus(5'b01000, 8'h60, '0, '0);
    for (int i = 0; i < 4; i++) applyStimulus(5'b10000, 8'(8'h61 + i), '0, '0);
    checkOutput("t6_busy4", 64'(sw_busy), 64'h10);
    resp_ready = 1'b0;
    applyStimulus('0, '0, 5'b01000, slice(3, 8'hB3));
    tick();
    checkOutput("t6_pre_rst", 64'(resp_valid), 64'd1);
    doReset();
    checkOutput("t6_rst_out", 64'({resp_valid, resp_data, resp_op_id, resp_sw_idx, sw_busy}), 64'd0);
    resp_ready = 1'b1;
    applyStimulus('0, '0, 5'b11000, slice(3, 8'hB4) | slice(4, 8'hB5));
    drain(3);
    checkOutput("t6_post_rst", 64'({resp_valid, sw_busy}), 64'd0);
    checkOutput("final_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
